// File: rtl/param_fwd_pipe.sv
// param_fwd_pipe: 3-stage (ID/EX/WB) NOP/ADD/SUB/AND pipeline on an NREG x DW register file.
// Build option PFP_FORWARD_EN: EX/WB operand bypass; when undefined, RAW hazards are interlocked.
module param_fwd_pipe #(
    parameter int  DW   = 8,
    parameter int  NREG = 4,
    parameter int  CNTW = 16,
    localparam int RW   = $clog2(NREG),
    localparam int IW   = 2 + 3 * RW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [RW-1:0]     dbg_raddr,
    output logic [DW-1:0]     dbg_rdata,
    input  logic              dbg_we,
    input  logic [RW-1:0]     dbg_waddr,
    input  logic [DW-1:0]     dbg_wdata,
    output logic              wb_valid,
    output logic [RW-1:0]     wb_rd,
    output logic [DW-1:0]     wb_data,
    output logic [2*NREG-1:0] sb_state,
    output logic [CNTW-1:0]   retire_cnt
);
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_AND = 2'b11
    } op_e;

    logic [DW-1:0]        rf [NREG];
    logic [NREG-1:0][1:0] sb;    // sb[i] = {writer of i in EX, writer of i in WB}

    op_e           id_op;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic [DW-1:0] id_a, id_b;
    logic          accept, writer;

    logic          ex_wen;
    op_e           ex_op;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_result;

    assign id_op  = op_e'(inst[IW-1 -: 2]);
    assign id_rs1 = inst[3*RW-1 -: RW];
    assign id_rs2 = inst[2*RW-1 -: RW];
    assign id_rd  = inst[RW-1:0];

`ifdef PFP_FORWARD_EN
    assign inst_ready = 1'b1;
`else
    assign inst_ready = !(inst_valid && (id_op != OP_NOP) &&
                          ((sb[id_rs1] != 2'b00) || (sb[id_rs2] != 2'b00)));
`endif

    assign accept = inst_valid && inst_ready;
    assign writer = accept && (id_op != OP_NOP);

    // Operand select; the newest producer (EX) takes precedence over WB.
    always_comb begin
        // NOTE: defaults first so every path assigns both operands; no latch is inferred.
        id_a = rf[id_rs1];
        id_b = rf[id_rs2];
`ifdef PFP_FORWARD_EN
        if (sb[id_rs1][1])      id_a = ex_result;
        else if (sb[id_rs1][0]) id_a = wb_data;
        if (sb[id_rs2][1])      id_b = ex_result;
        else if (sb[id_rs2][0]) id_b = wb_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            // NOTE: non-blocking so every bit shifts from the pre-edge scoreboard.
            for (int i = 0; i < NREG; i++)
                sb[i] <= {writer && (id_rd == RW'(i)), sb[i][1]};
        end
    end

    assign sb_state = sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wen <= 1'b0;
            ex_op  <= OP_NOP;
        end else begin
            ex_wen <= writer;
            ex_op  <= accept ? id_op : OP_NOP;
        end
    end

    // Payload registers carry no reset: they are only consumed when the matching wen/sb bit is set.
    always_ff @(posedge clk) begin
        ex_rd <= id_rd;
        ex_a  <= id_a;
        ex_b  <= id_b;
    end

    always_comb begin
        ex_result = '0;
        case (ex_op)
            OP_ADD:  ex_result = ex_a + ex_b;
            OP_SUB:  ex_result = ex_a - ex_b;
            OP_AND:  ex_result = ex_a & ex_b;
            default: ex_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) wb_valid <= 1'b0;
        else     wb_valid <= ex_wen;
    end

    always_ff @(posedge clk) begin
        wb_rd   <= ex_rd;
        wb_data <= ex_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is architecturally cleared on reset, so it is built from flops.
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            if (dbg_we)   rf[dbg_waddr] <= dbg_wdata;
            if (wb_valid) rf[wb_rd]     <= wb_data;  // later assignment wins a same-address collision
        end
    end

    assign dbg_rdata = rf[dbg_raddr];

    always_ff @(posedge clk) begin
        if (rst)           retire_cnt <= '0;
        else if (wb_valid) retire_cnt <= retire_cnt + 1'b1;
    end

endmodule
